// File: rtl/ram_portb_arbiter.sv
// ram_portb_arbiter
//   Shares port B of the dual-port instruction/data RAM between two masters:
//   M0 (core load/store unit) and M1 (debug/program loader). The arbiter is
//   round-robin and serves one access per cycle. Responses are registered.
//   Illegal accesses are still granted, but they never reach the RAM. These
//   are misaligned accesses, out-of-range accesses, and writes with an
//   unsupported byte-enable pattern.
//
// Ports
//   clk, rstn_i                   clock, asynchronous active-low reset
//   mX_req_i / mX_addr_i          request and byte address (held until grant)
//   mX_we_i / mX_be_i / mX_wdata_i write flag, byte enables, LSB-aligned data
//   mX_gnt_o                      combinational grant
//   mX_rvalid_o / mX_err_o        one-cycle response pulse, error qualifier
//   mX_rdata_o                    read data (0 for writes and errors)
//   m1_lock_i                     M1 keeps priority while locked and requesting
//   ram_en_o / ram_addr_o         RAM port-B enable and byte address
//   ram_we_o / ram_din_o          RAM byte-write mask and write data
//   ram_dout_i                    RAM read data, combinational from ram_addr_o

module ram_portb_arbiter #(
  parameter int unsigned SIZE = 1024
) (
  input  logic        clk,
  input  logic        rstn_i,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  input  logic        m1_lock_i,

  output logic        ram_en_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_we_o,
  output logic [31:0] ram_din_o,
  input  logic [31:0] ram_dout_i
);

  // last_gnt: 0 = M0 was granted last, 1 = M1 was granted last
  logic        last_gnt;
  logic        lock_owner;
  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;

  logic [31:0] sel_addr;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic [31:0] word_idx;
  logic        be_ok;
  logic        legal;
  logic        access;

  logic        m0_rvalid_q, m1_rvalid_q;
  logic        m0_err_q, m1_err_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  // A single requester always wins. On a tie, a locked M1 that already owns
  // the port keeps it. Otherwise the master that did not win last time gets
  // the grant. The lock only takes effect after M1 has won at least once.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (lock_owner && m1_lock_i) begin
        gnt1 = 1'b1;
      end else if (last_gnt) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = m0_req_i;
      gnt1 = m1_req_i;
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Fields of whichever master holds the grant this cycle
  assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
  assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
  assign sel_be    = gnt1 ? m1_be_i    : m0_be_i;
  assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

  // Legality: the address must be word aligned and inside the RAM. A write
  // may only use a full-word, low-halfword or low-byte mask.
  assign word_idx = {2'b00, sel_addr[31:2]};
  assign be_ok    = !sel_we || (sel_be == 4'b1111) || (sel_be == 4'b0011)
                    || (sel_be == 4'b0001);
  assign legal    = (sel_addr[1:0] == 2'b00) && (word_idx < SIZE) && be_ok;
  assign access   = any_gnt && legal;

  // Only a legal grant touches the RAM. Every other case keeps the port quiet.
  assign ram_en_o   = access;
  assign ram_addr_o = access ? sel_addr  : 32'h0;
  assign ram_din_o  = access ? sel_wdata : 32'h0;
  assign ram_we_o   = (access && sel_we) ? sel_be : 4'b0000;

  // Arbitration history. Reset makes last_gnt = 1 so that M0 wins the first
  // tie. lock_owner follows the most recent cycle, so it drops as soon as M1
  // loses the grant or releases the lock.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_gnt   <= 1'b1;
      lock_owner <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_gnt <= gnt1;
      end
      lock_owner <= gnt1 & m1_lock_i;
    end
  end

  // Responses are one-cycle pulses to the master granted on the previous
  // edge. Read data is captured at the grant edge. A write to the same word
  // commits on that edge too, so a read granted next cycle sees the new data.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
    end else begin
      m0_rvalid_q <= gnt0;
      m1_rvalid_q <= gnt1;
      m0_err_q    <= gnt0 & ~legal;
      m1_err_q    <= gnt1 & ~legal;
      m0_rdata_q  <= (gnt0 && legal && !sel_we) ? ram_dout_i : 32'h0;
      m1_rdata_q  <= (gnt1 && legal && !sel_we) ? ram_dout_i : 32'h0;
    end
  end

  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_err_o    = m0_err_q;
  assign m1_err_o    = m1_err_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// tb_ram_portb_arbiter
//   Drives ram_portb_arbiter against a behavioural RAM. A reference model
//   tracks arbitration, legality and memory contents at the transaction
//   level. It is checked every cycle. Directed scenarios with literal
//   expectations come first, followed by a randomized phase.

module tb_ram_portb_arbiter;

  localparam int SIZE = 1024;

  logic        clk = 1'b0;
  logic        rstn_i;

  logic        m0_req_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i;
  logic [3:0]  m0_be_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_rdata_o;

  logic        m1_req_i, m1_we_i, m1_lock_i;
  logic [31:0] m1_addr_i, m1_wdata_i;
  logic [3:0]  m1_be_i;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_rdata_o;

  logic        ram_en_o;
  logic [31:0] ram_addr_o, ram_din_o, ram_dout_i;
  logic [3:0]  ram_we_o;

  int checks = 0;
  int errors = 0;

  ram_portb_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .m1_lock_i(m1_lock_i),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, byte-masked write on the clock edge
  logic [31:0] mem [0:1023];
  assign ram_dout_i = mem[ram_addr_o[11:2]];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);
    forever begin
      @(posedge clk);
      if (rstn_i && ram_en_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_we_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_din_o[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic r0, input logic [31:0] a0, input logic w0, input logic [3:0] b0, input logic [31:0] d0,
    input logic r1, input logic [31:0] a1, input logic w1, input logic [3:0] b1, input logic [31:0] d1,
    input logic lk);
    m0_req_i = r0; m0_addr_i = a0; m0_we_i = w0; m0_be_i = b0; m0_wdata_i = d0;
    m1_req_i = r1; m1_addr_i = a1; m1_we_i = w1; m1_be_i = b1; m1_wdata_i = d1;
    m1_lock_i = lk;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randReq(output logic r, output logic [31:0] a, output logic w,
                         output logic [3:0] b, output logic [31:0] d);
    int kind;
    r = ($urandom_range(0, 3) != 0);
    kind = int'($urandom_range(0, 9));
    if (kind == 0)      a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else if (kind == 1) a = 32'(SIZE * 4) + (32'($urandom_range(0, 255)) << 2);
    else                a = 32'($urandom_range(0, 31)) << 2;
    w = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0:       b = 4'hF;
      1:       b = 4'h3;
      2:       b = 4'h1;
      default: b = 4'($urandom_range(0, 15));
    endcase
    d = $urandom;
  endtask

  // Reference model: which master owns the port, whether M1 holds a lock,
  // what each master should see next cycle, and the expected memory image.
  logic [31:0] ref_mem [0:1023];
  int          m_last;
  logic        m_lock;
  logic        exp_v [2];
  logic        exp_e [2];
  logic [31:0] exp_d [2];
  logic        mreq [2];
  logic [31:0] maddr [2];
  logic        mwe [2];
  logic [3:0]  mbe [2];
  logic [31:0] mwd [2];

  initial begin : model
    int w;
    int idx;
    logic illegal;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);
    m_last = 1; m_lock = 1'b0;
    exp_v[0] = 1'b0; exp_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        checkBit("rst_m0_rvalid", m0_rvalid_o, 1'b0);
        checkBit("rst_m1_rvalid", m1_rvalid_o, 1'b0);
        checkBit("rst_m0_err", m0_err_o, 1'b0);
        checkBit("rst_m1_err", m1_err_o, 1'b0);
        m_last = 1; m_lock = 1'b0;
        exp_v[0] = 1'b0; exp_v[1] = 1'b0;
      end else begin
        checkBit("m0_rvalid", m0_rvalid_o, exp_v[0]);
        checkBit("m1_rvalid", m1_rvalid_o, exp_v[1]);
        if (exp_v[0]) begin
          checkBit("m0_err", m0_err_o, exp_e[0]);
          checkOutput("m0_rdata", m0_rdata_o, exp_d[0]);
        end
        if (exp_v[1]) begin
          checkBit("m1_err", m1_err_o, exp_e[1]);
          checkOutput("m1_rdata", m1_rdata_o, exp_d[1]);
        end

        mreq[0] = m0_req_i; maddr[0] = m0_addr_i; mwe[0] = m0_we_i; mbe[0] = m0_be_i; mwd[0] = m0_wdata_i;
        mreq[1] = m1_req_i; maddr[1] = m1_addr_i; mwe[1] = m1_we_i; mbe[1] = m1_be_i; mwd[1] = m1_wdata_i;

        w = -1;
        if (mreq[0] && !mreq[1])      w = 0;
        else if (mreq[1] && !mreq[0]) w = 1;
        else if (mreq[0] && mreq[1])  w = (m_lock && m1_lock_i) ? 1 : 1 - m_last;

        checkBit("m0_gnt", m0_gnt_o, w == 0);
        checkBit("m1_gnt", m1_gnt_o, w == 1);
        exp_v[0] = (w == 0);
        exp_v[1] = (w == 1);

        if (w >= 0) begin
          illegal = (maddr[w] % 4 != 0) || (maddr[w] / 4 >= SIZE) ||
                    (mwe[w] && !(mbe[w] == 4'hF || mbe[w] == 4'h3 || mbe[w] == 4'h1));
          exp_e[w] = illegal;
          if (illegal) begin
            checkBit("ram_en_illegal", ram_en_o, 1'b0);
            checkOutput("ram_we_illegal", 32'(ram_we_o), 32'h0);
            exp_d[w] = 32'h0;
          end else begin
            idx = int'(maddr[w] / 4);
            checkBit("ram_en", ram_en_o, 1'b1);
            checkOutput("ram_addr", ram_addr_o, maddr[w]);
            checkOutput("ram_we", 32'(ram_we_o), mwe[w] ? 32'(mbe[w]) : 32'h0);
            checkOutput("ram_din", ram_din_o, mwd[w]);
            exp_d[w] = mwe[w] ? 32'h0 : ref_mem[idx];
            if (mwe[w])
              for (int b = 0; b < 4; b++)
                if (mbe[w][b]) ref_mem[idx][8*b +: 8] = mwd[w][8*b +: 8];
          end
          m_last = w;
          m_lock = (w == 1) && m1_lock_i;
        end else begin
          checkBit("ram_en_idle", ram_en_o, 1'b0);
          checkOutput("ram_we_idle", 32'(ram_we_o), 32'h0);
          checkOutput("ram_addr_idle", ram_addr_o, 32'h0);
          checkOutput("ram_din_idle", ram_din_o, 32'h0);
          m_lock = 1'b0;
        end
      end
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic
  initial begin : stimulus
    logic [31:0] t4_addr [3];
    logic        t4_we [3];
    logic [3:0]  t4_be [3];
    logic        g0, g1;

    t4_addr[0] = 32'h10;   t4_we[0] = 1'b1; t4_be[0] = 4'b0100;
    t4_addr[1] = 32'h6;    t4_we[1] = 1'b0; t4_be[1] = 4'b0000;
    t4_addr[2] = 32'h1000; t4_we[2] = 1'b0; t4_be[2] = 4'b0000;

    rstn_i = 1'b0;
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    checkBit("reset_m0_rvalid", m0_rvalid_o, 1'b0);
    checkBit("reset_m1_rvalid", m1_rvalid_o, 1'b0);
    checkOutput("reset_m0_rdata", m0_rdata_o, 32'h0);
    checkOutput("reset_m1_rdata", m1_rdata_o, 32'h0);
    @(negedge clk);
    #2 rstn_i = 1'b1;
    tick();

    // Both masters request continuously: grants alternate, M0 first
    applyStimulus(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBit("t2_m0_gnt", m0_gnt_o, (i % 2) == 0);
      checkBit("t2_m1_gnt", m1_gnt_o, (i % 2) == 1);
      if (i > 0) checkBit("t2_prev_rvalid", (i % 2 == 1) ? m0_rvalid_o : m1_rvalid_o, 1'b1);
      tick();
    end
    applyIdle();
    @(negedge clk);
    checkBit("t2_last_rvalid", m1_rvalid_o, 1'b1);
    tick();

    // Single M0 read of word 2
    applyStimulus(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkBit("t1_gnt", m0_gnt_o, 1'b1);
    checkBit("t1_ram_en", ram_en_o, 1'b1);
    checkOutput("t1_ram_we", 32'(ram_we_o), 32'h0);
    tick();
    applyIdle();
    @(negedge clk);
    checkBit("t1_rvalid", m0_rvalid_o, 1'b1);
    checkBit("t1_err", m0_err_o, 1'b0);
    checkOutput("t1_rdata", m0_rdata_o, 32'hA500_0002);
    tick();

    // M1 halfword write, then M0 reads the merged word back
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h40, 1'b1, 4'b0011, 32'h0000_BEEF, 1'b0);
    @(negedge clk);
    checkBit("t3_m1_gnt", m1_gnt_o, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkBit("t3_m0_gnt", m0_gnt_o, 1'b1);
    tick();
    applyIdle();
    @(negedge clk);
    checkOutput("t3_rdata", m0_rdata_o, 32'hA500_BEEF);
    tick();

    // Illegal accesses: bad byte enable, misaligned, out of range
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, t4_addr[k], t4_we[k], t4_be[k], 32'hDEAD_BEEF,
                    1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      @(negedge clk);
      checkBit("t4_gnt", m0_gnt_o, 1'b1);
      checkBit("t4_ram_en", ram_en_o, 1'b0);
      tick();
      applyIdle();
      @(negedge clk);
      checkBit("t4_err", m0_err_o, 1'b1);
      checkOutput("t4_rdata", m0_rdata_o, 32'h0);
      tick();
    end
    checkOutput("t4_mem_unchanged", mem[4], 32'hA500_0004);

    // Locked M1 burst holds the port against a waiting M0
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h24, 1'b0, 4'h0, 32'h0, 1'b1, 32'h20, 1'b1, 4'hF, 32'(i), 1'b1);
      @(negedge clk);
      checkBit("t5_m1_gnt", m1_gnt_o, 1'b1);
      checkBit("t5_m0_wait", m0_gnt_o, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h24, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkBit("t5_m0_gnt", m0_gnt_o, 1'b1);
    tick();
    applyIdle();
    tick();

    // Asynchronous reset while a response is outstanding
    applyStimulus(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();
    applyIdle();
    @(negedge clk);
    #2 rstn_i = 1'b0;
    #1;
    checkBit("t6_rvalid_async", m0_rvalid_o, 1'b0);
    checkBit("t6_err_async", m0_err_o, 1'b0);
    checkOutput("t6_rdata_async", m0_rdata_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2 rstn_i = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkBit("t6_m0_first", m0_gnt_o, 1'b1);
    checkBit("t6_m1_waits", m1_gnt_o, 1'b0);
    tick();
    applyIdle();

    // Randomized traffic; each master holds its request until granted
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      tick();
      if (!m0_req_i || g0) randReq(m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i);
      if (!m1_req_i || g1) randReq(m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i);
      if ($urandom_range(0, 3) == 0) m1_lock_i = ~m1_lock_i;
    end
    tick();
    applyIdle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
